// File: rtl/tomasulo_alu_unit_pkg.sv
// Shared definitions for the Tomasulo integer ALU functional unit.
// Opcode values are agreed with the ALU reservation station.
package tomasulo_alu_unit_pkg;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_SLT  = 6;
    localparam int ALU_SLTU = 7;

endpackage

// File: rtl/tomasulo_alu_unit_alu_result_fifo.sv
// Small result queue between the ALU and the CDB.
// The head is visible combinationally so that a CDB request can go out in the same cycle.
module alu_result_fifo #(
    parameter int  WIDTH = 36,
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A push into a full queue is only legal when the head leaves on the same edge.
    assign w_do_push = i_push && ((r_count < DEPTH_C) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);

endmodule

// File: rtl/tomasulo_alu_unit.sv
// Integer ALU functional unit: single-cycle ops, two-stage subtract, results queued for the CDB.
// Issue is blocked while a subtract is in its second stage, so results retire in accept order.
module tomasulo_alu_unit
    import tomasulo_alu_unit_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  LABEL_W = 4,
    parameter int  OP_W    = 3,
    parameter int  DEPTH   = 2,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               WEN,
    input  logic [OP_W-1:0]    op,
    input  logic [DATA_W-1:0]  dataIn1,
    input  logic [DATA_W-1:0]  dataIn2,
    input  logic [LABEL_W-1:0] labelIn,
    output logic               available,
    output logic               require,
    input  logic               requireAC,
    output logic [DATA_W-1:0]  result,
    output logic [LABEL_W-1:0] labelOut,
    output logic [CNT_W-1:0]   occupancy,
    output logic               inverseBusy
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic                       r_inv_busy;
    logic [DATA_W-1:0]          r_sub_a;
    logic [DATA_W-1:0]          r_sub_inv;
    logic [LABEL_W-1:0]         r_sub_label;

    logic                       w_pop;
    logic                       w_accept;
    logic                       w_is_sub;
    logic                       w_push;
    logic                       w_empty;
    logic [DATA_W-1:0]          w_alu_result;
    logic [DATA_W-1:0]          w_push_result;
    logic [LABEL_W-1:0]         w_push_label;
    logic [DATA_W+LABEL_W-1:0]  w_head;
    logic [CNT_W-1:0]           w_count;

    assign w_pop     = !w_empty && requireAC;
    assign available = !r_inv_busy && ((w_count < DEPTH_C) || w_pop);
    assign w_accept  = WEN && available;
    assign w_is_sub  = (op == OP_W'(ALU_SUB));

    always_comb begin
        w_alu_result = '0;
        case (op)
            OP_W'(ALU_ADD):  w_alu_result = dataIn1 + dataIn2;
            OP_W'(ALU_AND):  w_alu_result = dataIn1 & dataIn2;
            OP_W'(ALU_OR):   w_alu_result = dataIn1 | dataIn2;
            OP_W'(ALU_XOR):  w_alu_result = dataIn1 ^ dataIn2;
            OP_W'(ALU_NOR):  w_alu_result = ~(dataIn1 | dataIn2);
            OP_W'(ALU_SLT):  w_alu_result = {{(DATA_W-1){1'b0}}, ($signed(dataIn1) < $signed(dataIn2))};
            OP_W'(ALU_SLTU): w_alu_result = {{(DATA_W-1){1'b0}}, (dataIn1 < dataIn2)};
            default:         w_alu_result = '0;
        endcase
    end

    // Subtract stage one: capture the minuend and the two's-complement of the subtrahend.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_inv_busy  <= 1'b0;
            r_sub_a     <= '0;
            r_sub_inv   <= '0;
            r_sub_label <= '0;
        end else begin
            r_inv_busy <= w_accept && w_is_sub;
            if (w_accept && w_is_sub) begin
                r_sub_a     <= dataIn1;
                r_sub_inv   <= ~dataIn2 + DATA_W'(1);
                r_sub_label <= labelIn;
            end
        end
    end

    assign w_push        = (w_accept && !w_is_sub) || r_inv_busy;
    assign w_push_result = r_inv_busy ? (r_sub_a + r_sub_inv) : w_alu_result;
    assign w_push_label  = r_inv_busy ? r_sub_label : labelIn;

    alu_result_fifo #(
        .WIDTH (DATA_W + LABEL_W),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk         (clk),
        .rst         (RST),
        .i_push      (w_push),
        .i_push_data ({w_push_label, w_push_result}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    assign require     = !w_empty;
    assign result      = w_empty ? '0 : w_head[DATA_W-1:0];
    assign labelOut    = w_empty ? '0 : w_head[DATA_W+LABEL_W-1:DATA_W];
    assign occupancy   = w_count;
    assign inverseBusy = r_inv_busy;

endmodule
